instr_fetch_unit: RTL and testbench

- Fetch stage of the RV32I core.
- Holds the PC and issues in-order word requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions in a small queue, and presents instr/pc/pc+4 to decode over a valid/ready handshake.
- Decode slices instr[31:7] for the immediate extender.
- Accepts a redirect from execute (branch/jump); redirect flushes all wrong-path work.

---
 rtl/instr_fetch_unit.sv | 106 ++++++++++
 tb/tb_instr_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage with credit-based imem requests, decode queue and redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect raises a sticky fault instead of masking low bits.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc_plus4,
    output logic        misalign_fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = DEPTH[CW:0];

    logic          run, fault, hs, push, pop;
    logic [31:0]   pc, target, last_instr, last_pc, last_plus4;
    logic [CW-1:0] inflight, drop, qcount;
    logic [AW-1:0] fwr, frd, qwr, qrd;
    logic [31:0]   fifo_pc [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target = redirect_pc;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) fault <= 1'b0;
        else if (redirect_valid) fault <= |redirect_pc[1:0];
`else
    assign target = redirect_pc & ~32'h3;
    assign fault  = 1'b0;
`endif

    // Credit covers both in-flight words and buffered words, so responses always have a slot
    assign imem_req_valid = run && !fault && ({1'b0, inflight} + {1'b0, qcount} < LIMIT);
    assign imem_req_addr  = pc;
    assign hs             = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && drop == '0 && !redirect_valid;
    assign pop            = dec_valid && dec_ready && !redirect_valid;
    assign dec_valid      = qcount != '0;
    assign dec_instr      = dec_valid ? q_instr[qrd] : last_instr;
    assign dec_pc         = dec_valid ? q_pc[qrd] : last_pc;
    assign dec_pc_plus4   = dec_valid ? q_pc[qrd] + 32'd4 : last_plus4;
    assign misalign_fault = fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            pc         <= RESET_PC;
            inflight   <= '0;
            drop       <= '0;
            qcount     <= '0;
            fwr        <= '0;
            frd        <= '0;
            qwr        <= '0;
            qrd        <= '0;
            last_instr <= '0;
            last_pc    <= '0;
            last_plus4 <= '0;
        end else begin
            run      <= 1'b1;
            inflight <= inflight + CW'(hs) - CW'(imem_rsp_valid);
            if (hs) fwr <= fwr + AW'(1);
            if (imem_rsp_valid) frd <= frd + AW'(1);
            if (dec_valid) begin
                last_instr <= q_instr[qrd];
                last_pc    <= q_pc[qrd];
                last_plus4 <= q_pc[qrd] + 32'd4;
            end
            if (redirect_valid) begin
                pc     <= target;
                drop   <= inflight + CW'(hs) - CW'(imem_rsp_valid);
                qcount <= '0;
                qwr    <= '0;
                qrd    <= '0;
            end else begin
                if (hs) pc <= pc + 32'd4;
                if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
                qcount <= qcount + CW'(push) - CW'(pop);
                if (push) qwr <= qwr + AW'(1);
                if (pop) qrd <= qrd + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs) fifo_pc[fwr] <= pc;
        if (push) begin
            q_instr[qwr] <= imem_rsp_data;
            q_pc[qwr]    <= fifo_pc[frd];
        end
    end

    rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> inflight != '0);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit with a latency-programmable memory model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    localparam logic [31:0] K = 32'h1357_9BDF;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid, dec_ready = 1'b0;
    logic [31:0] dec_instr, dec_pc, dec_pc_plus4;
    logic        misalign_fault;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4), .misalign_fault(misalign_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        int          due;
    } req_t;

    int          checks = 0, failures = 0, cyc = 0, lat = 1;
    req_t        pend[$];
    req_t        r;
    logic [31:0] exp_q[$];
    logic [31:0] log_addr[$];
    int          log_cyc[$];
    logic [31:0] e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] logged(input int i);
        return (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_BEEF;
    endfunction

    // Memory: in-order, word content = addr ^ K, response lat cycles after acceptance
    always @(posedge clk) begin
        cyc++;
        if (rst_n && imem_req_valid && imem_req_ready) begin
            pend.push_back('{a: imem_req_addr, due: cyc + lat - 1});
            log_addr.push_back(imem_req_addr);
            log_cyc.push_back(cyc);
        end
        #1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = r.a ^ K;
        end else begin
            imem_rsp_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && dec_valid && dec_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_dec actual_pc=%h required=none", dec_pc);
            end else begin
                e = exp_q.pop_front();
                check("dec_pc", dec_pc, e);
                check("dec_instr", dec_instr, e ^ K);
                check("dec_pc_plus4", dec_pc_plus4, e + 32'd4);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_pc    = t;
        redirect_valid = 1'b1;
        step(1);
        redirect_valid = 1'b0;
        exp_q.delete();
        log_addr.delete();
        log_cyc.delete();
    endtask

    task automatic drain(input int budget);
        dec_ready = 1'b1;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1);
        check("drain_left", exp_q.size(), 0);
        dec_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        #3;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, 0);
        check("rst_dec_valid", dec_valid, 0);
        check("rst_dec_instr", dec_instr, 0);
        check("rst_dec_pc", dec_pc, 0);
        check("rst_dec_pc_plus4", dec_pc_plus4, 0);
        check("rst_fault", misalign_fault, 0);

        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        dec_ready = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b1;
        drain(30);
        check("t1_addr0", logged(0), 32'h0);
        check("t1_addr1", logged(1), 32'h4);
        check("t1_addr2", logged(2), 32'h8);
        check("t1_b2b", (log_cyc.size() > 1) ? log_cyc[1] - log_cyc[0] : -1, 1);

        redirect(32'h0);
        step(10);
        check("t2_stall_count", log_addr.size(), 2);
        check("t2_stall_addr0", logged(0), 32'h0);
        check("t2_stall_addr1", logged(1), 32'h4);
        check("t2_stall_req_valid", imem_req_valid, 0);
        check("t2_stall_dec_valid", dec_valid, 1);
        check("t2_stall_dec_pc", dec_pc, 32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        drain(30);
        check("t2_resume_addr", logged(2), 32'h8);

        lat = 6;
        redirect(32'h40);
        for (int i = 0; i < 20 && log_addr.size() < 2; i++) step(1);
        check("t3_two_inflight", log_addr.size(), 2);
        check("t3_credit_block", imem_req_valid, 0);
        redirect(32'h100);
        lat = 1;
        exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        drain(60);
        check("t3_first_addr", logged(0), 32'h100);

        redirect(32'h200);
        for (int i = 0; i < 16; i++) exp_q.push_back(32'h200 + 32'(4 * i));
        dec_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_rsp_valid && imem_req_valid && imem_req_ready) begin
                found = 1;
                break;
            end
            step(1);
        end
        check("t4_collision_seen", found, 1);
        redirect(32'h300);
        exp_q.push_back(32'h300); exp_q.push_back(32'h304); exp_q.push_back(32'h308);
        drain(30);
        check("t4_first_addr", logged(0), 32'h300);

        redirect(32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        drain(30);
        check("t5_wrap_addr0", logged(0), 32'hFFFF_FFFC);
        check("t5_wrap_addr1", logged(1), 32'h0);

        redirect(32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("t6_fault_set", misalign_fault, 1);
        step(6);
        check("t6_no_requests", log_addr.size(), 0);
        check("t6_req_valid", imem_req_valid, 0);
        check("t6_dec_valid", dec_valid, 0);
        redirect(32'h200);
        check("t6_fault_clear", misalign_fault, 0);
        exp_q.push_back(32'h200); exp_q.push_back(32'h204);
        drain(30);
        check("t6_first_addr", logged(0), 32'h200);
`else
        check("t6_fault_zero", misalign_fault, 0);
        exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        drain(30);
        check("t6_first_addr", logged(0), 32'h100);
        check("t6_fault_still_zero", misalign_fault, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
